// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared types and helpers for the push-button front end
//
// Purpose: channel FSM state encoding, event bit positions inside the
// per-channel {long,fall,rise} enable field, and a counter width helper.
// Ports: none (package).

package btn_debounce_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CAND_H = 2'd1,
    HIGH   = 2'd2,
    CAND_L = 2'd3
  } btn_state_e;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_LONG = 2;

  // Bits needed to hold any value 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, debounce FSM, event pulses
//
// Purpose: synchronises a raw pin, debounces it against a shared ms tick and
// emits registered rise / fall / long-press one-cycle pulses.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   pin_i      raw asynchronous button pin
//   tick_i     shared millisecond tick (one cycle wide)
//   level_o    debounced logical level, 1 = pressed
//   rise_o     pulse on debounced press
//   fall_o     pulse on debounced release
//   long_o     pulse once when a press has been held LONGPRESS_MS ticks

module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS  = 10,
  parameter int LONGPRESS_MS = 1000,
  parameter int SYNC_STAGES  = 2,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  input  logic tick_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  localparam int DB_W   = cnt_width(DEBOUNCE_MS);
  localparam int HOLD_W = cnt_width(LONGPRESS_MS);

  // Synchroniser resets to the idle pin level so the logical value starts at 0.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  btn_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d, db_inc;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              long_q, long_d;

  assign db_inc   = db_cnt_q + 1'b1;
  assign hold_inc = hold_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOW;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      long_q     <= long_d;
    end
  end

  // A change of s is tested before the tick, so a tick arriving together
  // with the move into a candidate state is never counted.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    long_d     = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s) begin
          state_d  = CAND_H;
          db_cnt_d = '0;
        end
      end
      CAND_H: begin
        if (!s) begin
          state_d = LOW;
        end else if (tick_i) begin
          if (db_inc == DB_W'(DEBOUNCE_MS)) begin
            state_d    = HIGH;
            hold_cnt_d = '0;
            level_d    = 1'b1;
            rise_d     = 1'b1;
          end else begin
            db_cnt_d = db_inc;
          end
        end
      end
      HIGH: begin
        if (!s) begin
          state_d  = CAND_L;
          db_cnt_d = '0;
        end else if (tick_i && (hold_cnt_q != HOLD_W'(LONGPRESS_MS))) begin
          // Saturating at LONGPRESS_MS keeps the long event to one per press.
          hold_cnt_d = hold_inc;
          long_d     = (hold_inc == HOLD_W'(LONGPRESS_MS));
        end
      end
      CAND_L: begin
        // hold_cnt is left untouched so a release bounce resumes the press.
        if (s) begin
          state_d = HIGH;
        end else if (tick_i) begin
          if (db_inc == DB_W'(DEBOUNCE_MS)) begin
            state_d = LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            db_cnt_d = db_inc;
          end
        end
      end
      default: state_d = LOW;
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign long_o  = long_q;

endmodule

// File: rtl/btn_debounce_irq.sv
// rtl/btn_debounce_irq.sv - N-channel debounced buttons with maskable pending interrupt
//
// Purpose: shared ms prescaler, NUM_CH debounce channels, per-channel pending
// flags set by enabled events, and a single interrupt line.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   btn_i        raw button pins
//   btn_o        debounced levels, 1 = pressed
//   rise_o       press pulses
//   fall_o       release pulses
//   long_o       long-press pulses
//   irq_en_i     per channel {long,fall,rise} enables at [3i+2:3i]
//   irq_clr_i    write-1-to-clear pending
//   irq_pend_o   pending flags
//   irq_o        OR of pending flags

module btn_debounce_irq
  import btn_debounce_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CLK_FREQ_HZ  = 25000000,
  parameter int DEBOUNCE_MS  = 10,
  parameter int LONGPRESS_MS = 1000,
  parameter int SYNC_STAGES  = 2,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     btn_i,
  output logic [NUM_CH-1:0]     btn_o,
  output logic [NUM_CH-1:0]     rise_o,
  output logic [NUM_CH-1:0]     fall_o,
  output logic [NUM_CH-1:0]     long_o,
  input  logic [3*NUM_CH-1:0]   irq_en_i,
  input  logic [NUM_CH-1:0]     irq_clr_i,
  output logic [NUM_CH-1:0]     irq_pend_o,
  output logic                  irq_o
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int PRE_W    = cnt_width(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONGPRESS_MS(LONGPRESS_MS),
      .SYNC_STAGES (SYNC_STAGES),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (btn_i[g]),
      .tick_i (tick),
      .level_o(btn_o[g]),
      .rise_o (rise_o[g]),
      .fall_o (fall_o[g]),
      .long_o (long_o[g])
    );
  end

  logic [NUM_CH-1:0] ev_hit;
  logic [NUM_CH-1:0] pend_q, pend_d;

  // Set has priority over clear; masking an event later leaves pend alone.
  always_comb begin
    ev_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ev_hit[i] = (rise_o[i] & irq_en_i[3*i+EV_RISE]) |
                  (fall_o[i] & irq_en_i[3*i+EV_FALL]) |
                  (long_o[i] & irq_en_i[3*i+EV_LONG]);
    end
    pend_d = ev_hit | (pend_q & ~irq_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign irq_pend_o = pend_q;
  assign irq_o      = |pend_q;

endmodule

// File: tb/tb_btn_debounce_irq.sv
// tb/tb_btn_debounce_irq.sv - self-checking bench for btn_debounce_irq

module tb_btn_debounce_irq;

  localparam int NCH   = 4;
  localparam int TDIV  = 4;
  localparam int DEB   = 3;
  localparam int LONGP = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   btn = '0;
  logic [3*NCH-1:0] irq_en = '0;
  logic [NCH-1:0]   irq_clr = '0;
  logic [NCH-1:0]   btn_w, rise_w, fall_w, long_w, pend_w;
  logic             irq_w;

  btn_debounce_irq #(
    .NUM_CH(NCH), .CLK_FREQ_HZ(4000), .DEBOUNCE_MS(DEB),
    .LONGPRESS_MS(LONGP), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .btn_i(btn), .btn_o(btn_w), .rise_o(rise_w),
    .fall_o(fall_w), .long_o(long_w), .irq_en_i(irq_en), .irq_clr_i(irq_clr),
    .irq_pend_o(pend_w), .irq_o(irq_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected within %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Reference model: the level follows s once s has differed from it for a
  // run containing DEB ticks after the run's first cycle; ticks are counted
  // from absolute time since reset. Long fires when ticks spent steadily
  // pressed since the rise reach LONGP.
  int             m_n;
  bit             m_l[NCH];
  int             m_streak[NCH];
  int             m_held[NCH];
  bit             m_p1[NCH], m_p2[NCH];
  logic [NCH-1:0] exp_btn = '0, exp_rise = '0, exp_fall = '0, exp_long = '0, exp_pend = '0;
  logic           exp_irq = 1'b0;

  function automatic int ticks_upto(input int m);
    return (m + 1) / TDIV;
  endfunction

  task automatic model_step();
    logic [NCH-1:0] nxt_pend, r, f, l;
    bit tk, s;
    if (rst) begin
      m_n = 0;
      for (int c = 0; c < NCH; c++) begin
        m_l[c] = 0; m_streak[c] = -1; m_held[c] = 0; m_p1[c] = 0; m_p2[c] = 0;
      end
      exp_btn = '0; exp_rise = '0; exp_fall = '0; exp_long = '0; exp_pend = '0; exp_irq = 1'b0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      nxt_pend[c] = (exp_rise[c] & irq_en[3*c]) | (exp_fall[c] & irq_en[3*c+1]) |
                    (exp_long[c] & irq_en[3*c+2]) | (exp_pend[c] & ~irq_clr[c]);
    end
    tk = ((m_n % TDIV) == TDIV - 1);
    r = '0; f = '0; l = '0;
    for (int c = 0; c < NCH; c++) begin
      s = m_p2[c];
      if (m_l[c] && m_streak[c] < 0 && s && tk) begin
        m_held[c]++;
        if (m_held[c] == LONGP) l[c] = 1'b1;
      end
      if (s == m_l[c]) begin
        m_streak[c] = -1;
      end else if (m_streak[c] < 0) begin
        m_streak[c] = m_n;
      end else if (ticks_upto(m_n) - ticks_upto(m_streak[c]) == DEB) begin
        m_l[c] = s;
        if (s) begin r[c] = 1'b1; m_held[c] = 0; end
        else f[c] = 1'b1;
        m_streak[c] = -1;
      end
      m_p2[c] = m_p1[c];
      m_p1[c] = btn[c];
    end
    for (int c = 0; c < NCH; c++) exp_btn[c] = m_l[c];
    exp_rise = r; exp_fall = f; exp_long = l;
    exp_pend = nxt_pend;
    exp_irq  = |nxt_pend;
    m_n++;
  endtask

  // Per-cycle comparison plus pulse bookkeeping for the literal checks.
  int rise_cnt[NCH], fall_cnt[NCH], long_cnt[NCH], rise_at[NCH], long_at[NCH];

  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (rise_w[c]) begin rise_cnt[c]++; rise_at[c] = cyc; end
      if (fall_w[c]) fall_cnt[c]++;
      if (long_w[c]) begin long_cnt[c]++; long_at[c] = cyc; end
    end
    chk("btn_o", 32'(btn_w), 32'(exp_btn));
    chk("rise_o", 32'(rise_w), 32'(exp_rise));
    chk("fall_o", 32'(fall_w), 32'(exp_fall));
    chk("long_o", 32'(long_w), 32'(exp_long));
    chk("irq_pend_o", 32'(pend_w), 32'(exp_pend));
    chk("irq_o", 32'(irq_w), 32'(exp_irq));
  end

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  int press_at, r0, dur[NCH];
  bit found;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; long_cnt[c] = 0; rise_at[c] = 0; long_at[c] = 0; dur[c] = 0;
    end
    run(1);
    chk("reset_btn_o", 32'(btn_w), 0);
    chk("reset_pend", 32'(pend_w), 0);
    chk("reset_irq", 32'(irq_w), 0);
    rst = 1'b0;
    run(3);

    // Clean press on channel 0.
    btn[0] = 1'b1; press_at = cyc;
    run(40);
    chk("s1_rise_count", rise_cnt[0], 1);
    chk("s1_level", 32'(btn_w[0]), 1);
    chk_rng("s1_press_latency", rise_at[0] - press_at, 11, 15);
    chk("s1_others_quiet", rise_cnt[1] + rise_cnt[2] + rise_cnt[3], 0);
    btn[0] = 1'b0;
    run(20);
    chk("s1_fall_count", fall_cnt[0], 1);

    // Bounce on channel 2: 3 cycles high / 3 low for 30 cycles, then high.
    for (int k = 0; k < 5; k++) begin
      btn[2] = 1'b1; run(3);
      btn[2] = 1'b0; run(3);
    end
    btn[2] = 1'b1;
    run(5);
    chk("s2_no_rise_in_bounce", rise_cnt[2], 0);
    chk("s2_no_fall_in_bounce", fall_cnt[2], 0);
    run(25);
    chk("s2_single_rise", rise_cnt[2], 1);
    btn[2] = 1'b0;
    run(20);

    // Glitch on channel 1.
    btn[1] = 1'b1; run(6);
    btn[1] = 1'b0; run(20);
    chk("s3_glitch_rise", rise_cnt[1], 0);
    chk("s3_glitch_fall", fall_cnt[1], 0);

    // Long press on channel 3.
    btn[3] = 1'b1; run(60);
    chk("s4_long_once", long_cnt[3], 1);
    chk("s4_long_delay", long_at[3] - rise_at[3], 40);
    btn[3] = 1'b0; run(20);
    chk("s4_fall", fall_cnt[3], 1);
    chk("s4_no_repeat", long_cnt[3], 1);

    // Interrupt path: rise enabled on ch1 only.
    irq_en = 12'h008;
    btn[0] = 1'b1; run(25);
    chk("s5_ch0_masked", 32'(irq_w), 0);
    btn[1] = 1'b1; run(25);
    chk("s5_ch1_pend", 32'(pend_w), 32'h2);
    chk("s5_ch1_irq", 32'(irq_w), 1);
    btn[1] = 1'b0; run(25);
    chk("s5_pend_held", 32'(pend_w), 32'h2);
    btn[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      run(1);
      if (rise_w[1]) found = 1'b1;
    end
    chk("s5_rise_seen", 32'(found), 1);
    irq_clr = 4'b0010; run(1);
    irq_clr = 4'b0000; run(1);
    chk("s5_set_beats_clr", 32'(pend_w), 32'h2);
    irq_clr = 4'b0010; run(1);
    irq_clr = 4'b0000; run(1);
    chk("s5_clear", 32'(irq_w), 0);

    // Reset mid-operation.
    btn = '0; run(25);
    irq_en = 12'h249;
    btn[1] = 1'b1; run(20);
    chk("s6_pend_before", 32'(pend_w[1]), 1);
    btn[0] = 1'b1; run(5);
    chk("s6_cand", 32'(btn_w[0]), 0);
    r0 = rise_cnt[0];
    rst = 1'b1;
    #1;
    chk("s6_rst_btn", 32'(btn_w), 0);
    chk("s6_rst_pend", 32'(pend_w), 0);
    chk("s6_rst_irq", 32'(irq_w), 0);
    run(2);
    rst = 1'b0;
    run(25);
    chk("s6_rise_after_rst", rise_cnt[0] - r0, 1);
    chk("s6_level_after_rst", 32'(btn_w[0]), 1);

    // Randomised phase.
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (dur[c] == 0) begin
          btn[c] = ~btn[c];
          dur[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(10, 70);
        end else begin
          dur[c]--;
        end
      end
      if (k % 64 == 0) irq_en = 12'($urandom);
      irq_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1; run(2); rst = 1'b0;
      end
      run(1);
    end
    btn = '0; irq_clr = '0;
    run(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
